tdm_demux_1x4: RTL

- Receive-side counterpart of the 4:1 channel multiplexer: recovers four 1-bit lanes from a time-division-multiplexed serial stream, one bit per slot, slots 0..3 per frame.
- A frame marker (sync, asserted with the slot-0 bit) is tracked by a hunt/check/lock state machine with flywheel slot counting.
- Emits the reassembled 4-bit lane word once per frame while locked.
- Sits at the far end of a serial link that is driven by the mux-based TDM transmitter.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/tdm_lock_fsm.sv | 161 ++++++++++++++++
 rtl/tdm_demux_1x4.sv | 95 +++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Brief    : Shared constants and state encoding for the TDM mux/demux pair.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  // Index of the final slot in a frame; the frame is complete after it.
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } tdm_state_t;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage
`default_nettype wire

// File: rtl/tdm_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tdm_lock_fsm
// Brief    : Frame-alignment state machine for the TDM demux. Tracks the sync
//            marker through HUNT/CHECK/LOCKED, runs the flywheel slot counter
//            and tells the datapath where to store each sample, when a frame
//            is complete and when a partial frame must be thrown away.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_lock_fsm
  import tdm_pkg::*;
#(
  parameter int LOCK_COUNT = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_valid,
  input  logic  i_sync,
  output logic  o_wr,
  output slot_t o_wr_idx,
  output logic  o_emit,
  output logic  o_drop,
  output logic  o_sync_err,
  output logic  o_locked
);

  localparam logic [2:0] c_LOCK = 3'(LOCK_COUNT);
  localparam logic [2:0] c_MISS = 3'(MISS_LIMIT);

  tdm_state_t r_state;
  slot_t      r_slot;
  logic [2:0] r_good;
  logic [2:0] r_err;
  logic       r_sync_err;
  logic       r_locked;

  tdm_state_t w_nstate;
  slot_t      w_nslot;
  logic [2:0] w_ngood;
  logic [2:0] w_nerr;
  logic       w_err;
  logic       w_wr;
  slot_t      w_idx;
  logic       w_emit;
  logic       w_drop;

  // Next-state decode for one qualified sample; nothing moves when i_valid is low.
  always_comb begin
    w_nstate = r_state;
    w_nslot  = r_slot;
    w_ngood  = r_good;
    w_nerr   = r_err;
    w_err    = 1'b0;
    w_wr     = 1'b0;
    w_idx    = r_slot;
    w_emit   = 1'b0;
    w_drop   = 1'b0;
    if (i_valid) begin
      case (r_state)
        HUNT: begin
          if (i_sync) begin
            w_wr     = 1'b1;
            w_idx    = '0;
            w_nslot  = slot_t'(1);
            w_ngood  = 3'd1;
            w_nerr   = 3'd0;
            w_nstate = (c_LOCK == 3'd1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (r_slot == '0) begin
            if (i_sync) begin
              w_wr    = 1'b1;
              w_idx   = '0;
              w_nslot = slot_t'(1);
              w_ngood = r_good + 3'd1;
              if ((r_good + 3'd1) >= c_LOCK) begin
                w_nstate = LOCKED;
              end
            end else begin
              // Expected marker never showed up: start hunting afresh.
              w_err    = 1'b1;
              w_drop   = 1'b1;
              w_nstate = HUNT;
              w_nslot  = '0;
              w_ngood  = 3'd0;
            end
          end else if (i_sync) begin
            // Marker arrived early: treat this sample as the new slot 0.
            w_err   = 1'b1;
            w_wr    = 1'b1;
            w_idx   = '0;
            w_nslot = slot_t'(1);
            w_ngood = 3'd1;
          end else begin
            w_wr    = 1'b1;
            w_nslot = r_slot + slot_t'(1);
          end
        end
        LOCKED: begin
          // Flywheel: the counter always advances, the marker only scores errors.
          w_wr    = 1'b1;
          w_nslot = r_slot + slot_t'(1);
          w_err   = (r_slot == '0) ? !i_sync : i_sync;
          if (w_err) begin
            if ((r_err + 3'd1) >= c_MISS) begin
              w_wr     = 1'b0;
              w_drop   = 1'b1;
              w_nstate = HUNT;
              w_nslot  = '0;
              w_ngood  = 3'd0;
              w_nerr   = 3'd0;
            end else begin
              w_nerr = r_err + 3'd1;
            end
          end else if (r_slot == '0) begin
            w_nerr = 3'd0;
          end
          if ((r_slot == SLOT_LAST) && !w_drop) begin
            w_emit = 1'b1;
          end
        end
        default: begin
          w_nstate = HUNT;
          w_nslot  = '0;
          w_ngood  = 3'd0;
          w_nerr   = 3'd0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_slot     <= '0;
      r_good     <= 3'd0;
      r_err      <= 3'd0;
      r_sync_err <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_slot     <= w_nslot;
      r_good     <= w_ngood;
      r_err      <= w_nerr;
      r_sync_err <= w_err;
      r_locked   <= (w_nstate == LOCKED);
    end
  end

  assign o_wr       = w_wr;
  assign o_wr_idx   = w_idx;
  assign o_emit     = w_emit;
  assign o_drop     = w_drop;
  assign o_sync_err = r_sync_err;
  assign o_locked   = r_locked;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_1x4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1x4
// Brief    : 1:4 TDM demultiplexer. Reassembles four 1-bit lanes from a serial
//            slot stream aligned by a slot-0 sync marker; emits one lane word
//            per frame while locked.
//            Optional macro TDM_DEMUX_STATS_EN adds err_total[7:0], a
//            saturating count of sync errors.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int LOCK_COUNT = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 sync,
  input  logic                 din_valid,
  output logic [NUM_SLOTS-1:0] out,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_DEMUX_STATS_EN
  ,
  output logic [7:0]           err_total
`endif
);

  logic                 w_wr;
  slot_t                w_wr_idx;
  logic                 w_emit;
  logic                 w_drop;
  logic [NUM_SLOTS-1:0] r_shift;
  logic [NUM_SLOTS-1:0] r_out;
  logic                 r_out_valid;

  tdm_lock_fsm #(
    .LOCK_COUNT (LOCK_COUNT),
    .MISS_LIMIT (MISS_LIMIT)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (din_valid),
    .i_sync     (sync),
    .o_wr       (w_wr),
    .o_wr_idx   (w_wr_idx),
    .o_emit     (w_emit),
    .o_drop     (w_drop),
    .o_sync_err (sync_err),
    .o_locked   (locked)
  );

  // Collect slot bits and publish the completed word on the slot-3 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_drop) begin
        r_shift <= '0;
      end else if (w_wr) begin
        r_shift[w_wr_idx] <= din;
      end
      if (w_emit) begin
        r_out       <= {din, r_shift[NUM_SLOTS-2:0]};
        r_out_valid <= 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef TDM_DEMUX_STATS_EN
  logic [7:0] r_err_total;

  // Saturating tally of sync errors; survives loss of lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_total <= 8'd0;
    end else if (sync_err && (r_err_total != 8'hFF)) begin
      r_err_total <= r_err_total + 8'd1;
    end
  end

  assign err_total = r_err_total;
`endif

endmodule
`default_nettype wire
